// File: rtl/adio_pkg.sv
// Shared constants and types for the codec serial audio path (ADC receive / DAC transmit).
package adio_pkg;
    localparam int DATA_WIDTH_DEF  = 16;
    localparam int LOCK_FRAMES_DEF = 2;

    // iCLK_18_4 cycles per BCK half-period and per LRCK half-period.
    localparam int BCK_HALF_DIV    = 6;
    localparam int LRCK_HALF_DIV   = 192;

    typedef enum logic [1:0] {
        ALIGN = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } rx_state_t;
endpackage

// File: rtl/adio_sync_edge.sv
// Two-flop synchronizer plus history register for one asynchronous codec pin.
// Edge pulses are held off until the whole chain holds real pin samples, so
// releasing reset while the pin sits high does not look like a pin edge.
module adio_sync_edge (
    input  logic iCLK_18_4,
    input  logic iRST_N,
    input  logic din,
    output logic level,
    output logic rise,
    output logic any_edge
);
    logic       meta;
    logic       sync;
    logic       hist;
    logic [2:0] prime;

    // Synchronizer chain, history stage and priming flags.
    always_ff @(posedge iCLK_18_4) begin
        if (!iRST_N) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            hist  <= 1'b0;
            prime <= '0;
        end else begin
            meta  <= din;
            sync  <= meta;
            hist  <= sync;
            prime <= {prime[1:0], 1'b1};
        end
    end

    assign level    = sync;
    assign rise     = prime[2] & sync & ~hist;
    assign any_edge = prime[2] & (sync ^ hist);
endmodule

// File: rtl/adio_adc_rx.sv
// Codec ADC serial receiver: left-justified MSB-first words, stereo pair out
// with a one-cycle valid strobe, lock after clean frames and a sticky framing error.
module adio_adc_rx
    import adio_pkg::*;
#(
    parameter int   DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int   LOCK_FRAMES = LOCK_FRAMES_DEF,
    parameter logic LEFT_LEVEL  = 1'b1
) (
    input  logic                  iCLK_18_4,
    input  logic                  iRST_N,
    input  logic                  iAUD_BCK,
    input  logic                  iAUD_ADCLRCK,
    input  logic                  iAUD_ADCDAT,
    input  logic                  iERR_CLR,
    output logic [DATA_WIDTH-1:0] oLEFT,
    output logic [DATA_WIDTH-1:0] oRIGHT,
    output logic                  oVALID,
    output logic                  oLOCK,
    output logic                  oERR
);
    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam int GW = $clog2(LOCK_FRAMES + 1);

    logic bck_lvl, bck_rise, bck_any;
    logic lr_lvl, lr_rise, lr_edge;
    logic dat_lvl, dat_rise, dat_any;

    // Identical paths keep data aligned with the clock edges it belongs to.
    adio_sync_edge u_bck (.iCLK_18_4(iCLK_18_4), .iRST_N(iRST_N), .din(iAUD_BCK),
                          .level(bck_lvl), .rise(bck_rise), .any_edge(bck_any));
    adio_sync_edge u_lrck (.iCLK_18_4(iCLK_18_4), .iRST_N(iRST_N), .din(iAUD_ADCLRCK),
                           .level(lr_lvl), .rise(lr_rise), .any_edge(lr_edge));
    adio_sync_edge u_dat (.iCLK_18_4(iCLK_18_4), .iRST_N(iRST_N), .din(iAUD_ADCDAT),
                          .level(dat_lvl), .rise(dat_rise), .any_edge(dat_any));

    wire unused = ^{bck_lvl, bck_any, lr_rise, dat_rise, dat_any};

    rx_state_t             state, state_nxt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CW-1:0]         cnt;
    logic                  chan_left;
    logic                  left_seen;
    logic [DATA_WIDTH-1:0] left_hold;
    logic [GW-1:0]         good_cnt;

    logic word_full, word_done, short_err, cap, new_left;

    assign word_full = (cnt == CW'(DATA_WIDTH));
    assign new_left  = (lr_lvl == LEFT_LEVEL);

    // State register.
    always_ff @(posedge iCLK_18_4) begin
        if (!iRST_N) state <= ALIGN;
        else         state <= state_nxt;
    end

    // Next state: any LRCK edge opens a new channel; a full word parks in HOLD.
    always_comb begin
        state_nxt = state;
        if (lr_edge) begin
            state_nxt = SHIFT;
        end else begin
            case (state)
                SHIFT:   if (word_full) state_nxt = HOLD;
                default: state_nxt = state;
            endcase
        end
    end

    // Control strobes; a BCK rise coincident with LRCK belongs to the new channel.
    always_comb begin
        word_done = 1'b0;
        short_err = 1'b0;
        cap       = 1'b0;
        if (state == SHIFT && word_full)  word_done = 1'b1;
        if (state == SHIFT && !word_full) short_err = lr_edge;
        if (bck_rise && (lr_edge || (state == SHIFT && !word_full))) cap = 1'b1;
    end

    // Shifting, word storage, frame completion, lock counting and error flag.
    always_ff @(posedge iCLK_18_4) begin
        if (!iRST_N) begin
            shreg     <= '0;
            cnt       <= '0;
            chan_left <= 1'b0;
            left_seen <= 1'b0;
            left_hold <= '0;
            oLEFT     <= '0;
            oRIGHT    <= '0;
            oVALID    <= 1'b0;
            good_cnt  <= '0;
            oERR      <= 1'b0;
        end else begin
            oVALID <= 1'b0;
            if (word_done) begin
                if (chan_left) begin
                    left_hold <= shreg;
                    left_seen <= 1'b1;
                end else if (left_seen) begin
                    // Right word goes straight out alongside the held left word.
                    oLEFT  <= left_hold;
                    oRIGHT <= shreg;
                    oVALID <= 1'b1;
                    if (good_cnt != GW'(LOCK_FRAMES)) good_cnt <= good_cnt + 1'b1;
                end
            end
            if (lr_edge) begin
                chan_left <= new_left;
                if (new_left) left_seen <= 1'b0;
                shreg <= cap ? {{(DATA_WIDTH-1){1'b0}}, dat_lvl} : '0;
                cnt   <= cap ? CW'(1) : '0;
                if (short_err) good_cnt <= '0;
            end else if (cap) begin
                shreg <= {shreg[DATA_WIDTH-2:0], dat_lvl};
                cnt   <= cnt + 1'b1;
            end
            if (short_err)     oERR <= 1'b1;
            else if (iERR_CLR) oERR <= 1'b0;
        end
    end

    assign oLOCK = (good_cnt == GW'(LOCK_FRAMES));
endmodule

// File: tb/tb_adio_adc_rx.sv
// Bench for adio_adc_rx: table of stereo frames plus hand-written corner sequences,
// with a scoreboard queue of expected output pairs.
module tb_adio_adc_rx;
    import adio_pkg::*;

    localparam int HALF = BCK_HALF_DIV;

    logic        clk = 1'b0;
    logic        rst_n, bck, lrck, dat, err_clr;
    logic [15:0] o_left, o_right;
    logic        o_valid, o_lock, o_err;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int rise_cyc = 0;
    int vcount = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        int          nl;
        int          nr;
        bit          pair;
        bit          lock;
        bit          err;
        bit          clr;
    } row_t;
    row_t rows[9];

    adio_adc_rx #(.DATA_WIDTH(16), .LOCK_FRAMES(2), .LEFT_LEVEL(1'b1)) dut (
        .iCLK_18_4(clk), .iRST_N(rst_n), .iAUD_BCK(bck), .iAUD_ADCLRCK(lrck),
        .iAUD_ADCDAT(dat), .iERR_CLR(err_clr), .oLEFT(o_left), .oRIGHT(o_right),
        .oVALID(o_valid), .oLOCK(o_lock), .oERR(o_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every valid pops one expected pair and must land 4 cycles after the 16th rise.
    always @(negedge clk) begin
        if (o_valid === 1'b1) begin
            vcount++;
            if (exp_q.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_valid actual=%h_%h expected=none", o_left, o_right);
            end else begin
                chk("valid_pair", {o_left, o_right}, exp_q.pop_front());
            end
            chk("valid_latency", cyc - rise_cyc, 4);
        end
    end

    function automatic logic [31:0] mkw(input logic [15:0] w, input int n);
        logic [31:0] x;
        x = {16'h0, w};
        if (n <= 16) return x >> (16 - n);
        return (x << (n - 16)) | ((32'h1 << (n - 16)) - 32'h1);
    endfunction

    // One channel, data changing on BCK fall; coinc moves the LRCK edge onto the first rise.
    task automatic send_chan(input logic lr, input logic [31:0] w, input int nbits, input bit coinc);
        for (int i = 0; i < nbits; i++) begin
            bck = 1'b0;
            dat = w[nbits-1-i];
            if (i == 0 && !coinc) lrck = lr;
            repeat (HALF) @(negedge clk);
            bck = 1'b1;
            if (i == 0 && coinc) lrck = lr;
            rise_cyc = cyc;
            repeat (HALF) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [15:0] l, input logic [15:0] r, input int nl,
                              input int nr, input bit coinc, input bit push);
        if (push) exp_q.push_back({l, r});
        send_chan(1'b1, mkw(l, nl), nl, coinc);
        send_chan(1'b0, mkw(r, nr), nr, coinc);
    endtask

    initial begin
        rows[0] = '{16'hA5C3, 16'h0F0F, 16, 16, 1, 0, 0, 0};
        rows[1] = '{16'hA5C3, 16'h0F0F, 16, 16, 1, 1, 0, 0};
        rows[2] = '{16'hA5C3, 16'h0F0F, 16, 16, 1, 1, 0, 0};
        rows[3] = '{16'hA5C3, 16'h0F0F, 16, 16, 1, 1, 0, 0};
        rows[4] = '{16'h1111, 16'h2222, 16, 12, 0, 1, 0, 0};
        rows[5] = '{16'h3333, 16'h4444, 16, 16, 1, 0, 1, 0};
        rows[6] = '{16'h5555, 16'h6666, 16, 16, 1, 1, 1, 1};
        rows[7] = '{16'h8001, 16'h8001, 20, 20, 1, 1, 0, 0};
        rows[8] = '{16'h7FFF, 16'h8000, 16, 16, 1, 1, 0, 0};

        rst_n = 1'b0; bck = 1'b0; lrck = 1'b0; dat = 1'b0; err_clr = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_left", o_left, 0);
        chk("rst_right", o_right, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_lock", o_lock, 0);
        chk("rst_err", o_err, 0);
        chk("rst_state", dut.state, ALIGN);

        // Reset released halfway through a left word.
        fork
            send_chan(1'b1, mkw(16'h1234, 16), 16, 1'b0);
            begin repeat (96) @(negedge clk); rst_n = 1'b1; end
        join
        send_chan(1'b0, mkw(16'h5678, 16), 16, 1'b0);
        chk("midstart_valids", vcount, 0);
        chk("midstart_err", o_err, 0);

        for (int k = 0; k < 9; k++) begin
            send_frame(rows[k].l, rows[k].r, rows[k].nl, rows[k].nr, 1'b0, rows[k].pair);
            chk($sformatf("row%0d_lock", k), o_lock, rows[k].lock);
            chk($sformatf("row%0d_err", k), o_err, rows[k].err);
            if (rows[k].clr) begin
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                chk($sformatf("row%0d_errclr", k), o_err, 0);
            end
        end

        // LRCK edge and BCK rise on the same cycle, MSB=1 on both channels.
        send_frame(16'h9ABC, 16'hF00D, 16, 16, 1'b1, 1'b1);
        chk("coinc_lock", o_lock, 1);
        chk("coinc_err", o_err, 0);

        // Short right word, then iERR_CLR lands exactly on the cycle the error sets.
        send_frame(16'h2468, 16'h1357, 16, 12, 1'b0, 1'b0);
        exp_q.push_back({16'hCAFE, 16'hBEEF});
        fork
            send_chan(1'b1, mkw(16'hCAFE, 16), 16, 1'b0);
            begin
                @(negedge clk); @(negedge clk);
                chk("errwin_pre", o_err, 0);
                err_clr = 1'b1;
                @(negedge clk);
                err_clr = 1'b0;
                chk("errwin_set", o_err, 1);
                chk("errwin_lock", o_lock, 0);
            end
        join
        send_chan(1'b0, mkw(16'hBEEF, 16), 16, 1'b0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("errwin_clr", o_err, 0);
        send_frame(16'h0001, 16'hFFFE, 16, 16, 1'b0, 1'b1);
        chk("prerst_lock", o_lock, 1);

        // One-cycle reset during bit 7 of a left word.
        fork
            send_chan(1'b1, mkw(16'h4321, 16), 16, 1'b0);
            begin
                repeat (87) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                chk("midrst_left", o_left, 0);
                chk("midrst_right", o_right, 0);
                chk("midrst_valid", o_valid, 0);
                chk("midrst_lock", o_lock, 0);
                chk("midrst_err", o_err, 0);
                chk("midrst_state", dut.state, ALIGN);
                rst_n = 1'b1;
            end
        join
        send_chan(1'b0, mkw(16'h8765, 16), 16, 1'b0);
        send_frame(16'hDEAD, 16'h0BAD, 16, 16, 1'b0, 1'b1);
        chk("postrst_lock", o_lock, 0);
        chk("postrst_err", o_err, 0);

        repeat (10) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
